// File: rtl/kof_pkg.sv
// Shared definitions for the fighting-game core: round state encoding,
// default health width and saturating arithmetic reused by the counters.
package kof_pkg;

   typedef enum logic {
      FIGHT = 1'b0,
      KO    = 1'b1
   } state_e;

   localparam int HPW_DEFAULT = 8;

   function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
      return (b > a) ? 32'd0 : a - b;
   endfunction

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] maxv);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s > {1'b0, maxv}) ? maxv : s[31:0];
   endfunction

endpackage

// File: rtl/hp_lane.sv
// One player's health and invulnerability counter. alive_o reflects the
// value being written this cycle so the round logic can decide in step.
module hp_lane
   import kof_pkg::*;
#(
   parameter int HPW        = HPW_DEFAULT,
   parameter int HP_INIT    = 100,
   parameter int INV_FRAMES = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           en_i,
   input  logic [HPW-1:0] dmg_i,
   input  logic [HPW-1:0] heal_i,
   output logic [HPW-1:0] hp_o,
   output logic           hit_o,
   output logic           alive_o
);

   localparam int IW = (INV_FRAMES > 0) ? $clog2(INV_FRAMES + 1) : 1;
   localparam logic [31:0] HP_MAX = 32'((33'd1 << HPW) - 33'd1);

   logic [HPW-1:0] hp_q, hp_d, post;
   logic [IW-1:0]  inv_q, inv_d;
   logic           hit_q, hit_d;

   always_comb begin
      hp_d  = hp_q;
      inv_d = inv_q;
      hit_d = 1'b0;
      post  = hp_q;
      if (en_i) begin
         if (inv_q == '0 && dmg_i != '0) begin
            post  = HPW'(sat_sub(32'(hp_q), 32'(dmg_i)));
            inv_d = IW'(INV_FRAMES);
            hit_d = 1'b1;
         end else if (inv_q != '0) begin
            inv_d = inv_q - IW'(1);
         end
         // A lane that reached zero never recovers through healing.
         if (post != '0) begin
            post = HPW'(sat_add(32'(post), 32'(heal_i), HP_MAX));
         end
         hp_d = post;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         hp_q  <= HPW'(HP_INIT);
         inv_q <= '0;
         hit_q <= 1'b0;
      end else begin
         hp_q  <= hp_d;
         inv_q <= inv_d;
         hit_q <= hit_d;
      end
   end

   assign hp_o    = hp_q;
   assign hit_o   = hit_q;
   assign alive_o = (hp_d != '0);

endmodule

// File: rtl/health_bank.sv
// Per-player health bank: frame-tick edge detection, NP health lanes and
// the round FSM that declares a winner (lowest surviving index) or a draw.
module health_bank
   import kof_pkg::*;
#(
   parameter int NP         = 2,
   parameter int HPW        = HPW_DEFAULT,
   parameter int HP_INIT    = 100,
   parameter int INV_FRAMES = 4,
   localparam int WW        = (NP > 2) ? $clog2(NP) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              keep,
   input  logic              fresh,
   input  logic [NP*HPW-1:0] dmg,
   input  logic [NP*HPW-1:0] heal,
   output logic [NP*HPW-1:0] blood,
   output logic [NP-1:0]     hit,
   output logic              over,
   output logic [WW-1:0]     winner,
   output logic              draw
);

   localparam int CW = $clog2(NP + 1);

   state_e         state_q, state_d;
   logic           fresh_q;
   logic           tick, en;
   logic [NP-1:0]  alive;
   logic [CW-1:0]  alive_cnt;
   logic [WW-1:0]  first_idx;
   logic           over_q, over_d, draw_q, draw_d;
   logic [WW-1:0]  winner_q, winner_d;

   // fresh_q resets high so a level held through reset is not a tick.
   always_ff @(posedge clk) begin
      if (!reset) fresh_q <= 1'b1;
      else        fresh_q <= fresh;
   end

   assign tick = fresh & ~fresh_q;
   assign en   = tick & ~keep & (state_q == FIGHT);

   for (genvar g = 0; g < NP; g++) begin : g_lane
      hp_lane #(
         .HPW        (HPW),
         .HP_INIT    (HP_INIT),
         .INV_FRAMES (INV_FRAMES)
      ) u_lane (
         .clk     (clk),
         .reset   (reset),
         .en_i    (en),
         .dmg_i   (dmg[g*HPW +: HPW]),
         .heal_i  (heal[g*HPW +: HPW]),
         .hp_o    (blood[g*HPW +: HPW]),
         .hit_o   (hit[g]),
         .alive_o (alive[g])
      );
   end

   always_comb begin
      alive_cnt = '0;
      first_idx = '0;
      for (int i = NP - 1; i >= 0; i--) begin
         if (alive[i]) begin
            alive_cnt = alive_cnt + CW'(1);
            first_idx = WW'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) state_q <= FIGHT;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (state_q == FIGHT && en && alive_cnt <= CW'(1)) state_d = KO;
   end

   always_comb begin
      over_d   = over_q;
      draw_d   = draw_q;
      winner_d = winner_q;
      if (state_q == FIGHT && state_d == KO) begin
         over_d   = 1'b1;
         draw_d   = (alive_cnt == '0);
         winner_d = (alive_cnt == '0) ? '0 : first_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         over_q   <= 1'b0;
         draw_q   <= 1'b0;
         winner_q <= '0;
      end else begin
         over_q   <= over_d;
         draw_q   <= draw_d;
         winner_q <= winner_d;
      end
   end

   assign over   = over_q;
   assign draw   = draw_q;
   assign winner = winner_q;

endmodule
